// File: rtl/mult4u_tr_seq.sv
// Time-redundant sequencer around a shared 4x4 unsigned multiplier.
// Runs (a,b) then (b,a), compares, retries on mismatch.
module mult4u_tr_seq #(
  parameter int SETTLE_CYCLES = 2,
  parameter int MAX_RETRY     = 2,
  parameter int CNT_W         = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [3:0]       in_a,
  input  logic [3:0]       in_b,
  output logic [3:0]       mul_a,
  output logic [3:0]       mul_b,
  input  logic [7:0]       mul_p,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [7:0]       out_p,
  output logic             out_err,
  output logic [CNT_W-1:0] mism_cnt
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_P1,
    S_P2,
    S_CMP,
    S_DONE
  } state_t;

  localparam logic [3:0]       LP_RELOAD = 4'(SETTLE_CYCLES - 1);
  localparam logic [2:0]       LP_MAXR   = 3'(MAX_RETRY);
  localparam logic [CNT_W-1:0] LP_ONE    = CNT_W'(1);
  localparam logic [CNT_W-1:0] LP_SAT    = '1;

  state_t           r_state;
  state_t           w_next;
  logic [3:0]       r_a;
  logic [3:0]       r_b;
  logic [3:0]       r_mul_a;
  logic [3:0]       r_mul_b;
  logic [7:0]       r_p1;
  logic [7:0]       r_p2;
  logic [3:0]       r_cnt;
  logic [2:0]       r_retry;
  logic             r_out_valid;
  logic [7:0]       r_out_p;
  logic             r_out_err;
  logic [CNT_W-1:0] r_mism;

  logic w_cnt_zero;
  logic w_match;
  logic w_can_retry;

  assign w_cnt_zero  = (r_cnt == 4'd0);
  assign w_match     = (r_p1 == r_p2);
  assign w_can_retry = (r_retry < LP_MAXR);

  assign in_ready  = (r_state == S_IDLE);
  assign mul_a     = r_mul_a;
  assign mul_b     = r_mul_b;
  assign out_valid = r_out_valid;
  assign out_p     = r_out_p;
  assign out_err   = r_out_err;
  assign mism_cnt  = r_mism;

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= S_IDLE;
    else        r_state <= w_next;
  end

  // Next-state decode
  always_comb begin
    w_next = r_state;
    unique case (r_state)
      S_IDLE: if (in_valid) w_next = S_P1;
      S_P1:   if (w_cnt_zero) w_next = S_P2;
      S_P2:   if (w_cnt_zero) w_next = S_CMP;
      S_CMP: begin
        if (w_match || !w_can_retry) w_next = S_DONE;
        else                         w_next = S_P1;
      end
      S_DONE: if (out_ready) w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  // Operand, sample, compare and result datapath
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_a         <= '0;
      r_b         <= '0;
      r_mul_a     <= '0;
      r_mul_b     <= '0;
      r_p1        <= '0;
      r_p2        <= '0;
      r_cnt       <= '0;
      r_retry     <= '0;
      r_out_valid <= 1'b0;
      r_out_p     <= '0;
      r_out_err   <= 1'b0;
      r_mism      <= '0;
    end else begin
      unique case (r_state)
        S_IDLE: begin
          if (in_valid) begin
            r_a     <= in_a;
            r_b     <= in_b;
            r_mul_a <= in_a;
            r_mul_b <= in_b;
            r_retry <= '0;
            r_cnt   <= LP_RELOAD;
          end
        end
        S_P1: begin
          if (w_cnt_zero) begin
            r_p1    <= mul_p;
            r_mul_a <= r_b;
            r_mul_b <= r_a;
            r_cnt   <= LP_RELOAD;
          end else begin
            r_cnt <= r_cnt - 4'd1;
          end
        end
        S_P2: begin
          if (w_cnt_zero) r_p2  <= mul_p;
          else            r_cnt <= r_cnt - 4'd1;
        end
        S_CMP: begin
          if (w_match) begin
            r_out_p     <= r_p1;
            r_out_err   <= 1'b0;
            r_out_valid <= 1'b1;
          end else begin
            if (r_mism != LP_SAT) r_mism <= r_mism + LP_ONE;
            if (w_can_retry) begin
              r_retry <= r_retry + 3'd1;
              r_mul_a <= r_a;
              r_mul_b <= r_b;
              r_cnt   <= LP_RELOAD;
            end else begin
              r_out_p     <= r_p1;
              r_out_err   <= 1'b1;
              r_out_valid <= 1'b1;
            end
          end
        end
        S_DONE: if (out_ready) r_out_valid <= 1'b0;
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_mult4u_tr_seq.sv
// Bench for mult4u_tr_seq: vector table, exhaustive and random
// jobs against a pass-level reference, plus fault/reset sequences.
module tb_mult4u_tr_seq;

  localparam int S = 2;

  logic       clk = 0;
  logic       rst_n;
  logic       in_valid, in_ready, out_valid, out_ready, out_err;
  logic [3:0] in_a, in_b, mul_a, mul_b;
  logic [7:0] mul_p, out_p;
  logic [7:0] mism_cnt;

  logic       in_valid2, in_ready2, out_valid2, out_ready2, out_err2;
  logic [3:0] in_a2, in_b2, mul_a2, mul_b2;
  logic [7:0] mul_p2, out_p2;
  logic [1:0] mism_cnt2;

  int fmode = 0;
  int p2hits = 0;
  int p2base = 0;
  int nchk = 0;
  int nerr = 0;

  always #5 clk = ~clk;

  mult4u_tr_seq dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_a(in_a), .in_b(in_b),
    .mul_a(mul_a), .mul_b(mul_b), .mul_p(mul_p),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_p(out_p), .out_err(out_err), .mism_cnt(mism_cnt)
  );

  mult4u_tr_seq #(.MAX_RETRY(4), .CNT_W(2)) dut2 (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid2), .in_ready(in_ready2),
    .in_a(in_a2), .in_b(in_b2),
    .mul_a(mul_a2), .mul_b(mul_b2), .mul_p(mul_p2),
    .out_valid(out_valid2), .out_ready(out_ready2),
    .out_p(out_p2), .out_err(out_err2), .mism_cnt(mism_cnt2)
  );

  function automatic logic [7:0] fm(input logic [3:0] x, y,
                                    input bit stuck);
    logic [7:0] r;
    r = {4'd0, x} * {4'd0, y};
    if (stuck && x > y) r[7] = 1'b1;
    return r;
  endfunction

  always @(posedge clk)
    if (mul_a == 4'd9 && mul_b == 4'd7) p2hits <= p2hits + 1;

  always_comb begin
    mul_p = fm(mul_a, mul_b, fmode == 2);
    if (fmode == 1 && mul_a == 4'd9 && mul_b == 4'd7 &&
        (p2hits - p2base) < S)
      mul_p = mul_p ^ 8'h08;
  end

  always_comb mul_p2 = fm(mul_a2, mul_b2, 1'b1);

  // Job-level model: each attempt is one pass pair.
  function automatic void ref_job(input logic [3:0] a, b,
                                  input int mode, input int maxr,
                                  output logic [7:0] p, output logic e,
                                  output int mism, output int lat);
    logic [7:0] p1, p2;
    mism = 0; lat = 0; p = 0; e = 0;
    for (int k = 0; k <= maxr; k++) begin
      p1 = fm(a, b, mode == 2);
      p2 = fm(b, a, mode == 2);
      if (mode == 1 && k == 0) p2 = p2 ^ 8'h08;
      lat += 2 * S + 1;
      if (p1 == p2) begin
        p = p1; e = 0;
        return;
      end
      mism++;
      p = p1; e = 1;
    end
  endfunction

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    nchk++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 0;
    @(negedge clk);
    rst_n = 1;
  endtask

  task automatic do_job(input logic [3:0] a, b, input int hold,
                        input bit noise, output logic [7:0] p,
                        output logic e, output int lat);
    bit busy_ok, hold_ok;
    logic [7:0] p0;
    logic e0;
    @(negedge clk);
    chk("in_ready_idle", 32'(in_ready), 1);
    in_valid = 1; in_a = a; in_b = b;
    out_ready = noise ? 1'($urandom) : 1'b0;
    @(posedge clk); #1;
    in_valid = 0; lat = 0; busy_ok = 1;
    while (!out_valid && lat < 200) begin
      if (in_ready) busy_ok = 0;
      if (noise) begin
        in_valid = 1'($urandom); in_a = 4'($urandom);
        in_b = 4'($urandom); out_ready = 1'($urandom);
      end
      @(posedge clk); #1;
      lat++;
    end
    chk("out_valid_seen", 32'(out_valid), 1);
    p0 = out_p; e0 = out_err; hold_ok = 1;
    out_ready = 0;
    repeat (hold) begin
      if (noise) begin
        in_valid = 1'($urandom); in_a = 4'($urandom);
        in_b = 4'($urandom);
      end
      @(posedge clk); #1;
      if (!out_valid || in_ready || out_p != p0 || out_err != e0)
        hold_ok = 0;
    end
    chk("busy_in_ready_low", 32'(busy_ok), 1);
    chk("hold_stable", 32'(hold_ok), 1);
    p = p0; e = e0;
    in_valid = 0; out_ready = 1;
    @(posedge clk); #1;
    out_ready = 0;
    chk("release_to_idle", {30'd0, out_valid, in_ready}, 32'b01);
  endtask

  typedef struct {
    logic [3:0] a;
    logic [3:0] b;
    int         hold;
    logic [7:0] p;
    logic       e;
  } vec_t;

  vec_t tbl[10];

  initial begin
    logic [7:0] p, rp;
    logic e, re;
    int lat, rl, rm, em, bad;

    tbl[0] = '{4'd13, 4'd11, 0, 8'h8F, 1'b0};
    tbl[1] = '{4'd0,  4'd0,  0, 8'h00, 1'b0};
    tbl[2] = '{4'd15, 4'd15, 0, 8'hE1, 1'b0};
    tbl[3] = '{4'd0,  4'd15, 0, 8'h00, 1'b0};
    tbl[4] = '{4'd15, 4'd0,  2, 8'h00, 1'b0};
    tbl[5] = '{4'd15, 4'd1,  1, 8'h0F, 1'b0};
    tbl[6] = '{4'd1,  4'd15, 0, 8'h0F, 1'b0};
    tbl[7] = '{4'd12, 4'd10, 3, 8'h78, 1'b0};
    tbl[8] = '{4'd7,  4'd9,  0, 8'h3F, 1'b0};
    tbl[9] = '{4'd8,  4'd8,  0, 8'h40, 1'b0};

    rst_n = 0;
    in_valid = 0; in_a = 0; in_b = 0; out_ready = 0;
    in_valid2 = 0; in_a2 = 0; in_b2 = 0; out_ready2 = 0;
    #12;
    chk("rst_out_valid", 32'(out_valid), 0);
    chk("rst_mul_ab", {24'd0, mul_a, mul_b}, 0);
    chk("rst_out_p_err", {23'd0, out_p, out_err}, 0);
    chk("rst_mism", 32'(mism_cnt), 0);
    @(negedge clk);
    rst_n = 1;
    #1;
    chk("rst_in_ready", 32'(in_ready), 1);

    // Basic job with an ideal multiplier
    do_job(4'd13, 4'd11, 0, 0, p, e, lat);
    chk("t1_p", 32'(p), 32'h8F);
    chk("t1_err", 32'(e), 0);
    chk("t1_lat", lat, 5);
    chk("t1_mism", 32'(mism_cnt), 0);

    for (int i = 0; i < 10; i++) begin
      do_job(tbl[i].a, tbl[i].b, tbl[i].hold, 0, p, e, lat);
      chk($sformatf("tbl%0d_p", i), 32'(p), 32'(tbl[i].p));
      chk($sformatf("tbl%0d_err", i), 32'(e), 32'(tbl[i].e));
    end

    bad = 0;
    for (int i = 0; i < 256; i++) begin
      logic [7:0] iv;
      iv = 8'(i);
      do_job(iv[7:4], iv[3:0], 0, 0, p, e, lat);
      ref_job(iv[7:4], iv[3:0], 0, 2, rp, re, rm, rl);
      chk($sformatf("exh_%0d_p", i), 32'(p), 32'(rp));
    end

    for (int i = 0; i < 40; i++) begin
      logic [3:0] ra, rb;
      ra = 4'($urandom); rb = 4'($urandom);
      do_job(ra, rb, $urandom_range(0, 4), 1, p, e, lat);
      ref_job(ra, rb, 0, 2, rp, re, rm, rl);
      chk("rnd_p", 32'(p), 32'(rp));
      chk("rnd_err", 32'(e), 32'(re));
      chk("rnd_lat", lat, rl);
    end
    chk("rnd_mism", 32'(mism_cnt), 0);

    // Backpressure with ignored requests while busy
    do_job(4'd6, 4'd5, 20, 1, p, e, lat);
    chk("bp_p", 32'(p), 32'd30);
    chk("bp_err", 32'(e), 0);

    // Transient fault on the first pass-2 sample
    do_reset();
    fmode = 1;
    p2base = p2hits;
    do_job(4'd7, 4'd9, 0, 0, p, e, lat);
    ref_job(4'd7, 4'd9, 1, 2, rp, re, rm, rl);
    chk("tr_p", 32'(p), 32'h3F);
    chk("tr_err", 32'(e), 0);
    chk("tr_lat", lat, 10);
    chk("tr_mism", 32'(mism_cnt), 1);
    chk("tr_model_lat", lat, rl);

    // Persistent stuck-at fault
    do_reset();
    fmode = 2;
    do_job(4'd3, 4'd5, 0, 0, p, e, lat);
    ref_job(4'd3, 4'd5, 2, 2, rp, re, rm, rl);
    chk("st_p", 32'(p), 32'h0F);
    chk("st_err", 32'(e), 1);
    chk("st_mism", 32'(mism_cnt), 3);
    chk("st_model_mism", 32'(mism_cnt), rm);
    chk("st_lat", lat, rl);

    // Reset pulse in the middle of pass 2
    do_reset();
    @(negedge clk);
    in_valid = 1; in_a = 4'd3; in_b = 4'd5;
    @(posedge clk); #1;
    in_valid = 0;
    repeat (3) @(posedge clk);
    #2 rst_n = 0;
    #1;
    chk("mr_out", {22'd0, out_valid, out_err, out_p}, 0);
    chk("mr_mul", {24'd0, mul_a, mul_b}, 0);
    chk("mr_mism", 32'(mism_cnt), 0);
    chk("mr_ready", 32'(in_ready), 1);
    @(negedge clk);
    rst_n = 1;
    bad = 0;
    repeat (15) begin
      @(posedge clk); #1;
      if (out_valid || !in_ready) bad++;
    end
    chk("mr_quiet", bad, 0);
    chk("mr_mism_after", 32'(mism_cnt), 0);
    fmode = 0;

    // Narrow counter saturation on the second instance
    @(negedge clk);
    in_valid2 = 1; in_a2 = 4'd3; in_b2 = 4'd5;
    @(posedge clk); #1;
    in_valid2 = 0; lat = 0;
    while (!out_valid2 && lat < 300) begin
      @(posedge clk); #1;
      lat++;
    end
    ref_job(4'd3, 4'd5, 2, 4, rp, re, rm, rl);
    em = (rm > 3) ? 3 : rm;
    chk("sat_valid", 32'(out_valid2), 1);
    chk("sat_lat", lat, rl);
    chk("sat_p", 32'(out_p2), 32'(rp));
    chk("sat_err", 32'(out_err2), 1);
    chk("sat_mism", 32'(mism_cnt2), em);
    out_ready2 = 1;
    @(posedge clk); #1;
    out_ready2 = 0;
    chk("sat_release", {30'd0, out_valid2, in_ready2}, 32'b01);
    chk("sat_hold", 32'(mism_cnt2), 3);

    $display("Simulation finished: %0d checks, %0d errors", nchk, nerr);
    $finish;
  end

endmodule
